// File: rtl/fregisters_sb_if.sv
// Bundle of read, write, scoreboard and debug signals for fregisters_sb.
// master drives addresses/writes/allocs; slave returns data, busy, errors.
interface fregisters_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 3
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD*AW-1:0]   iRdAddr;
  logic [NREAD*XLEN-1:0] oRdData;
  logic [NREAD-1:0]      oRdBusy;
  logic                  iWrEnA;
  logic [AW-1:0]         iWrAddrA;
  logic [XLEN-1:0]       iWrDataA;
  logic                  iWrEnB;
  logic [AW-1:0]         iWrAddrB;
  logic [XLEN-1:0]       iWrDataB;
  logic                  iAlloc;
  logic [AW-1:0]         iAllocAddr;
  logic                  iFlush;
  logic                  oAllocErr;
  logic                  oWawErr;
  logic [AW-1:0]         iDbgSel;
  logic [XLEN-1:0]       oDbgData;
  logic [AW:0]           oPendCount;

  modport master (
    output iRdAddr, iWrEnA, iWrAddrA, iWrDataA,
    output iWrEnB, iWrAddrB, iWrDataB,
    output iAlloc, iAllocAddr, iFlush, iDbgSel,
    input  oRdData, oRdBusy, oAllocErr, oWawErr,
    input  oDbgData, oPendCount
  );

  modport slave (
    input  iRdAddr, iWrEnA, iWrAddrA, iWrDataA,
    input  iWrEnB, iWrAddrB, iWrDataB,
    input  iAlloc, iAllocAddr, iFlush, iDbgSel,
    output oRdData, oRdBusy, oAllocErr, oWawErr,
    output oDbgData, oPendCount
  );
endinterface

// File: rtl/fregisters_sb.sv
// FP register file with per-register pending scoreboard, bypassed reads,
// fast (A) and completion (B) write ports, debug read and pending count.
module fregisters_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input logic            iCLK,
  input logic            iRSTn,
  fregisters_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]  dbg_q, dbg_d;
  logic             aerr_q, aerr_d;
  logic             werr_q, werr_d;

  logic wa_ok, wb_ok, al_ok;
  logic set_inc, clr_dec;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  assign wa_ok = bus.iWrEnA && !pend_q[bus.iWrAddrA]
              && !is_zero(bus.iWrAddrA);
  assign wb_ok = bus.iWrEnB && !is_zero(bus.iWrAddrB);
  assign al_ok = bus.iAlloc && !is_zero(bus.iAllocAddr);

  always_comb begin
    regs_d = regs_q;
    if (wa_ok) regs_d[bus.iWrAddrA] = bus.iWrDataA;
    // B is applied last so it wins a same-address collision
    if (wb_ok) regs_d[bus.iWrAddrB] = bus.iWrDataB;
  end

  always_comb begin
    pend_d = bus.iFlush ? '0 : pend_q;
    if (wb_ok) pend_d[bus.iWrAddrB] = 1'b0;
    if (al_ok) pend_d[bus.iAllocAddr] = 1'b1;
  end

  // A same-address alloc keeps the bit set, so B's clear is cancelled
  assign set_inc = al_ok && !pend_q[bus.iAllocAddr];
  assign clr_dec = wb_ok && pend_q[bus.iWrAddrB]
                && !(al_ok && bus.iAllocAddr == bus.iWrAddrB);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.iFlush)
      cnt_d = (AW+1)'(al_ok);
    else
      cnt_d = cnt_q + (AW+1)'(set_inc) - (AW+1)'(clr_dec);
  end

  always_comb begin
    werr_d = bus.iWrEnA && pend_q[bus.iWrAddrA]
          && !(bus.iWrEnB && bus.iWrAddrB == bus.iWrAddrA);
    aerr_d = al_ok && !bus.iFlush && pend_q[bus.iAllocAddr]
          && !(bus.iWrEnB && bus.iWrAddrB == bus.iAllocAddr);
    dbg_d  = regs_q[bus.iDbgSel];
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rbusy;
    assign ra = bus.iRdAddr[k*AW +: AW];
    always_comb begin
      rdat  = regs_q[ra];
      rbusy = pend_q[ra];
      if (is_zero(ra)) begin
        rdat  = '0;
        rbusy = 1'b0;
      end else if (bus.iWrEnB && bus.iWrAddrB == ra) begin
        rdat = bus.iWrDataB;
      end else if (wa_ok && bus.iWrAddrA == ra) begin
        rdat = bus.iWrDataA;
      end
    end
    assign bus.oRdData[k*XLEN +: XLEN] = rdat;
    assign bus.oRdBusy[k] = rbusy;
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      dbg_q  <= '0;
      aerr_q <= 1'b0;
      werr_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      dbg_q  <= dbg_d;
      aerr_q <= aerr_d;
      werr_q <= werr_d;
    end
  end

  assign bus.oPendCount = cnt_q;
  assign bus.oDbgData   = dbg_q;
  assign bus.oAllocErr  = aerr_q;
  assign bus.oWawErr    = werr_q;
endmodule

// File: doc/fregisters_sb.md
# fregisters_sb

Parametrised floating-point register file with an integrated per-register scoreboard, the successor to the single-write-port FP register bank in the core. It offers N combinational read ports with same-cycle write bypass, and two write ports: a single-cycle port for FPU ops and a completion port for multi-cycle units such as fdiv and fsqrt. It tracks pending destinations so the pipeline's hazard unit can stall on `oRdBusy`. It also provides a registered debug/VGA read port and a pending-count output.

## Interface
Parameters:
- `XLEN`, 32, register width in bits
- `NREGS`, 32, register count; power of two; `AW = $clog2(NREGS)`
- `NREAD`, 3, read ports (3 covers fused multiply-add)
- `ZERO_REG`, 0, if 1 register 0 reads as 0 and ignores writes and allocs (lets the same block serve as an integer file)

Ports:
- `iCLK`  in  1  clock; all state updates on posedge
- `iRSTn`  in  1  reset, asynchronous, active-low
- `iRdAddr`  in  NREAD*AW  packed read addresses; port k is at `[k*AW +: AW]`
- `oRdData`  out  NREAD*XLEN  packed read data, combinational
- `oRdBusy`  out  NREAD  pending bit of each addressed register, combinational
- `iWrEnA`, `iWrAddrA`, `iWrDataA`  in  1/AW/XLEN  single-cycle write port
- `iWrEnB`, `iWrAddrB`, `iWrDataB`  in  1/AW/XLEN  long-latency completion write port
- `iAlloc`, `iAllocAddr`  in  1/AW  mark a destination pending at issue
- `iFlush`  in  1  clear all pending bits (exception or pipeline flush)
- `oAllocErr`  out  1  one-cycle pulse: alloc to an already-pending register
- `oWawErr`  out  1  one-cycle pulse: port-A write to a pending register was dropped
- `iDbgSel`  in  AW  debug/VGA register select
- `oDbgData`  out  XLEN  registered debug read
- `oPendCount`  out  AW+1  number of pending bits set

## Operation
Reads:
- `oRdData[k]` is the write data of the highest-priority valid same-cycle write to the addressed register, otherwise the stored value.
- Priority for both storage and bypass: B over A.
- `oRdBusy[k]` reflects the current, pre-edge pending state.

Writes:
- Port B always writes and clears the pending bit of `iWrAddrB`.
- Port A writes only if the target's pending bit is 0. Otherwise the write is dropped and `oWawErr` pulses on the next cycle.
- A and B to the same address in the same cycle: B's data is stored; A is discarded with no error.

Scoreboard:
- `iAlloc` sets `pending[iAllocAddr]` at the edge.
- Alloc to a register already pending with no same-cycle B clear: the bit stays set and `oAllocErr` pulses.
- Alloc and B completion on the same address in the same cycle: data is written, the bit ends set (alloc wins), no error.
- `iFlush` clears every pending bit. A same-cycle alloc still sets its own bit.
- Flush does not cancel same-cycle writes.

Counter:
- `oPendCount` is registered and always equals popcount(pending) after each edge.
- It is updated incrementally (+1 alloc, −1 clear, net when both) or loaded on flush. It never wraps.

ZERO_REG=1:
- Address 0 always reads 0 with busy 0.
- Writes to address 0 have no effect.
- Alloc to address 0 is ignored, with no error and no count change.

## Timing
- Reset (`iRSTn` low, asynchronous, immediate): all registers 0, all pending 0, `oPendCount`=0, `oDbgData`=0, `oAllocErr`=0, `oWawErr`=0. Reset mid-operation discards any in-flight pending state.
- Read latency 0 (combinational, including bypass).
- Write, alloc and flush take effect at the next posedge.
- `oDbgData` = `registers[iDbgSel]` sampled one cycle after `iDbgSel`. It shows stored values only, no bypass.
- `oAllocErr` and `oWawErr` are registered and high for exactly one cycle following the offending edge.

## Test plan
- Reset/bypass: release `iRSTn`; write A f3=0x3F800000 while reading f3 -> `oRdData`=0x3F800000 in the same cycle. Next cycle the stored value is 0x3F800000 and `oDbgData` (sel=3) reads 0x3F800000 one cycle later.
- Scoreboard: alloc f5 -> `oRdBusy`=1, count=1. B writes f5=0x40490FDB -> busy 0, count 0, value readable.
- WAW drop: alloc f7, then A writes f7=0x1 -> f7 unchanged, `oWawErr` pulses once, count stays 1.
- Collisions: A and B to f9 same cycle -> B data stored. Alloc and B on f9 same cycle -> data written, busy remains 1. Second alloc on a pending register -> `oAllocErr` pulses.
- Flush: alloc f1, f2, f4 (count 3), then flush with alloc f6 in the same cycle -> only f6 pending, count=1.
- ZERO_REG=1, NREGS=16, NREAD=2: A write x0=0xFFFF and alloc x0 -> read 0, busy 0, count 0. Then assert async reset mid-sequence -> all outputs 0 immediately.
